// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RISC-V size
// codes and the byte count of an access.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      SZ_B, SZ_BU: size_bytes = 3'd1;
      SZ_H, SZ_HU: size_bytes = 3'd2;
      default:     size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_req_check.sv
// Combinational request checker: funct3 legality, natural alignment and
// memory range. Shared with the instruction-fetch path.
module lsu_req_check
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 65536,
  parameter int unsigned OFFSET_W  = 28
) (
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  output logic        err_o
);

  localparam logic [OFFSET_W:0] LIMIT = (OFFSET_W+1)'(MEM_BYTES);

  logic [2:0]        nbytes;
  logic              legal;
  logic              aligned;
  logic [OFFSET_W:0] end_off;
  logic              unused_addr_hi;

  // Upper address bits never reach memory, so they play no part in the range check.
  assign unused_addr_hi = ^addr_i[31:OFFSET_W];

  always_comb begin
    nbytes = size_bytes(funct3_i);
    case (funct3_i)
      SZ_B, SZ_H, SZ_W: legal = 1'b1;
      SZ_BU, SZ_HU:     legal = !we_i;
      default:          legal = 1'b0;
    endcase
    case (nbytes)
      3'd2:    aligned = !addr_i[0];
      3'd4:    aligned = (addr_i[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    // One extra bit keeps the end offset from wrapping near the top of the space.
    end_off = {1'b0, addr_i[OFFSET_W-1:0]} + {{(OFFSET_W-2){1'b0}}, nbytes};
    err_o   = !legal || !aligned || (end_off > LIMIT);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator driving a single-cycle data memory port.
// Optional perf counters are enabled by defining LSU_PERF_COUNTERS_EN.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 65536,
  parameter int unsigned OFFSET_W  = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
`ifdef LSU_PERF_COUNTERS_EN
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_errs,
`endif
  input  logic [31:0] mem_rdata
);

  lsu_state_t          state_q, state_d;
  logic                chk_err;
  logic                we_q;
  logic [OFFSET_W-1:0] mem_addr_q;
  logic [2:0]          mem_size_q;
  logic [31:0]         mem_wdata_q;
  logic                mem_wen_q;
  logic [31:0]         resp_rdata_q;
  logic                resp_err_q;

  lsu_req_check #(
    .MEM_BYTES (MEM_BYTES),
    .OFFSET_W  (OFFSET_W)
  ) u_check (
    .we_i     (req_we),
    .funct3_i (req_funct3),
    .addr_i   (req_addr),
    .err_o    (chk_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = chk_err ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
  end

  // The memory port registers double as the captured request; a rejected
  // request leaves them untouched so they keep their last driven values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_size_q   <= SZ_W;
      mem_wdata_q  <= '0;
      mem_wen_q    <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      mem_wen_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          we_q <= req_we;
          if (chk_err) begin
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            mem_addr_q  <= req_addr[OFFSET_W-1:0];
            mem_size_q  <= req_funct3;
            mem_wdata_q <= req_wdata;
            mem_wen_q   <= req_we;
          end
        end
        ACCESS: begin
          resp_err_q   <= 1'b0;
          resp_rdata_q <= we_q ? 32'd0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = {{(32-OFFSET_W){1'b0}}, mem_addr_q};
  assign mem_size   = mem_size_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wen    = mem_wen_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

`ifdef LSU_PERF_COUNTERS_EN
  logic [31:0] perf_loads_q, perf_stores_q, perf_errs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_loads_q  <= '0;
      perf_stores_q <= '0;
      perf_errs_q   <= '0;
    end else if (resp_valid && resp_ready) begin
      if (resp_err_q)  perf_errs_q   <= perf_errs_q + 32'd1;
      else if (we_q)   perf_stores_q <= perf_stores_q + 32'd1;
      else             perf_loads_q  <= perf_loads_q + 32'd1;
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
  assign perf_errs   = perf_errs_q;
`endif

endmodule
